// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and key-event output.
// Latency: event visible DEBOUNCE_CYCLES clocks after the capture sample.
// Backpressure: none upstream. KEYPAD_FIFO_EN defined -> 4-entry event FIFO popped by
//   key_rd, new events dropped when full (sticky overflow). Undefined -> one-clock pulse.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row_d,
  output logic [3:0] col_q,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_rd,
  output logic       overflow
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    pat_q;
  logic          push_q;
  logic [3:0]    push_code_q;
  logic          row_onehot;

  // Exactly one row active: a single key on the driven column.
  assign row_onehot = (row_d != 4'd0) && ((row_d & (row_d - 4'd1)) == 4'd0);

  // Hex code for a (one-hot row, one-hot column) pair.
  function automatic logic [3:0] key_map(input logic [3:0] row_oh, input logic [3:0] col_oh);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    r = 2'd0;
    c = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_oh[i]) r = 2'(i);
      if (col_oh[i]) c = 2'(i);
    end
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan/debounce FSM; the column only rotates when a column is finished with.
  // The event is registered once more (push_q) so key_valid rises exactly
  // DEBOUNCE_CYCLES clocks after the capture sample.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SCAN;
      col_q       <= 4'b0001;
      cnt_q       <= '0;
      pat_q       <= 4'd0;
      push_q      <= 1'b0;
      push_code_q <= 4'd0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (cnt_q == SETTLE_LAST) begin
            if (row_onehot) begin
              // Capture sample counts as the first stable match.
              pat_q   <= row_d;
              cnt_q   <= CW'(1);
              state_q <= DEBOUNCE;
            end else begin
              // No key or several keys: move on.
              cnt_q <= '0;
              col_q <= {col_q[2:0], col_q[3]};
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (row_d != pat_q) begin
            cnt_q   <= '0;
            state_q <= SCAN;
          end else if (cnt_q == DEB_LAST) begin
            push_q      <= 1'b1;
            push_code_q <= key_map(pat_q, col_q);
            cnt_q       <= '0;
            state_q     <= HELD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (row_d == 4'd0) begin
            // First released clock counts toward the release debounce.
            cnt_q   <= CW'(1);
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (row_d != 4'd0) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= '0;
            col_q   <= {col_q[2:0], col_q[3]};
            state_q <= SCAN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= SCAN;
        end
      endcase
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic [3:0] fifo_mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       overflow_q;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = key_rd && (count_q != 3'd0);
  // A pop in the same clock frees the slot, so a push while full still lands.
  assign do_push = push_q && ((count_q != 3'd4) || do_pop);

  // Event FIFO storage, pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= 4'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem_q[wr_ptr_q] <= push_code_q;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (push_q && !do_push) overflow_q <= 1'b1;
    end
  end

  assign key_valid = (count_q != 3'd0);
  assign key_code  = fifo_mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
`else
  logic       key_valid_q;
  logic [3:0] key_code_q;
  logic       unused_key_rd;

  assign unused_key_rd = key_rd;

  // One-clock valid pulse per event; code held until the next event.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      key_valid_q <= push_q;
      if (push_q) key_code_q <= push_code_q;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a simple 4x4 matrix model driving row_d.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] row_d;
  logic [3:0] col_q;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_rd;
  logic       overflow;

  // Matrix model: pressed keys on key_col show key_pat on the rows when that column is driven.
  logic [3:0] key_pat;
  logic [3:0] key_col;
  logic       auto_pop;
  int         n_vec = 0;
  int         n_err = 0;
  int         oh_bad = 0;

  assign row_d = ((col_q & key_col) != 4'd0) ? key_pat : 4'd0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(20)) dut (
    .clk(clk), .nrst(nrst), .row_d(row_d), .col_q(col_q),
    .key_valid(key_valid), .key_code(key_code), .key_rd(key_rd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst && ($countones(col_q) != 1)) oh_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    if (auto_pop) key_rd = key_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks_count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (key_valid) seen++;
    end
  endtask

  task automatic wait_event(input string tag, input int budget, output logic [3:0] code);
    logic found;
    found = 1'b0;
    code  = 4'd0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (key_valid) begin
        found = 1'b1;
        code  = key_code;
      end
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
  endtask

  typedef struct { logic [3:0] pat; logic [3:0] col; logic [3:0] code; } key_t;

  initial begin
    int         seen;
    int         changes;
    logic [3:0] exp_col;
    logic [3:0] prev_col;
    logic [3:0] code;
    key_t       keys [5];

    nrst = 1'b0; key_pat = 4'd0; key_col = 4'd0; key_rd = 1'b0; auto_pop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", {28'd0, col_q}, 32'h1);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    nrst = 1'b1;

    // Idle scan: 4 clocks per column, wrapping after column 3.
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_col = 4'b0001 << ((i / 4) % 4);
      check($sformatf("scan_col_t%0d", i), {28'd0, col_q}, {28'd0, exp_col});
      check($sformatf("scan_valid_t%0d", i), {31'd0, key_valid}, 32'd0);
    end

    // Key '6' (row 1, column 2). Column 2 is reached in 8 clocks, sampled 4 later,
    // then 19 more matches: 31 quiet clocks, event on the 32nd.
    key_col = 4'b0100; key_pat = 4'b0010;
    ticks_count_valid(31, seen);
    check("k6_quiet", seen, 0);
    tick();
    check("k6_valid", {31'd0, key_valid}, 32'd1);
    check("k6_code", {28'd0, key_code}, 32'h6);
    ticks_count_valid(60, seen);
    check("k6_no_repeat", seen, 0);
    check("k6_held_col", {28'd0, col_q}, 32'b0100);
    key_pat = 4'd0;
    ticks_count_valid(19, seen);
    check("k6_rel_col", {28'd0, col_q}, 32'b0100);
    tick();
    check("k6_rel_adv", {28'd0, col_q}, 32'b1000);
    check("k6_rel_quiet", seen, 0);

    // Bouncing key '1': toggles every 5 clocks for 40 clocks, then stable.
    key_col = 4'b0001;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      int s;
      key_pat = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      ticks_count_valid(5, s);
      seen += s;
    end
    check("bounce_quiet", seen, 0);
    key_pat = 4'b0001;
    ticks_count_valid(19, seen);
    check("bounce_min_stable", seen, 0);
    wait_event("bounce_evt", 80, code);
    check("bounce_code", {28'd0, code}, 32'h1);
    ticks_count_valid(40, seen);
    check("bounce_single", seen, 0);
    key_pat = 4'd0;
    repeat (30) tick();

    // Two rows active on every column: ignored, scan keeps advancing every 4 clocks.
    key_col = 4'b1111; key_pat = 4'b0011;
    changes = 0; seen = 0;
    for (int i = 0; i < 32; i++) begin
      prev_col = col_q;
      tick();
      if (col_q != prev_col) changes++;
      if (key_valid) seen++;
    end
    check("multi_adv", changes, 8);
    check("multi_quiet", seen, 0);
    key_pat = 4'd0; key_col = 4'd0;
    repeat (8) tick();

    // Key map spot checks.
    keys[0] = '{pat: 4'b0001, col: 4'b1000, code: 4'hA};
    keys[1] = '{pat: 4'b1000, col: 4'b0001, code: 4'hE};
    keys[2] = '{pat: 4'b1000, col: 4'b0100, code: 4'hF};
    keys[3] = '{pat: 4'b1000, col: 4'b1000, code: 4'hD};
    keys[4] = '{pat: 4'b0100, col: 4'b0010, code: 4'h8};
    for (int k = 0; k < 5; k++) begin
      key_col = keys[k].col; key_pat = keys[k].pat;
      wait_event($sformatf("map%0d", k), 80, code);
      check($sformatf("map%0d_code", k), {28'd0, code}, {28'd0, keys[k].code});
      key_pat = 4'd0;
      repeat (30) tick();
    end

    // Reset during HELD on key 'C' (row 2, column 3), then re-press.
    key_col = 4'b1000; key_pat = 4'b0100;
    wait_event("kc_evt", 80, code);
    check("kc_code", {28'd0, code}, 32'hC);
    repeat (5) tick();
    #2 nrst = 1'b0;
    #1;
    check("hold_rst_col", {28'd0, col_q}, 32'h1);
    check("hold_rst_valid", {31'd0, key_valid}, 32'd0);
    check("hold_rst_code", {28'd0, key_code}, 32'd0);
    check("hold_rst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1 nrst = 1'b1;
    // Column 3 sampled on clock 16 after release, event 20 clocks later.
    ticks_count_valid(35, seen);
    check("repress_quiet", seen, 0);
    tick();
    check("repress_valid", {31'd0, key_valid}, 32'd1);
    check("repress_code", {28'd0, key_code}, 32'hC);
    key_pat = 4'd0;
    repeat (30) tick();

`ifdef KEYPAD_FIFO_EN
    // Five presses without reading: four kept in order, fifth dropped.
    auto_pop = 1'b0; key_rd = 1'b0;
    keys[0] = '{pat: 4'b0001, col: 4'b0001, code: 4'h1};
    keys[1] = '{pat: 4'b0010, col: 4'b0010, code: 4'h5};
    keys[2] = '{pat: 4'b0100, col: 4'b0100, code: 4'h9};
    keys[3] = '{pat: 4'b1000, col: 4'b1000, code: 4'hD};
    keys[4] = '{pat: 4'b0001, col: 4'b0010, code: 4'h2};
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("fifo_ovf_before", {31'd0, overflow}, 32'd0);
      key_col = keys[k].col; key_pat = keys[k].pat;
      repeat (60) tick();
      key_pat = 4'd0;
      repeat (30) tick();
    end
    check("fifo_ovf_after", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fifo_valid%0d", k), {31'd0, key_valid}, 32'd1);
      check($sformatf("fifo_code%0d", k), {28'd0, key_code}, {28'd0, keys[k].code});
      key_rd = 1'b1;
      tick();
      key_rd = 1'b0;
    end
    check("fifo_empty", {31'd0, key_valid}, 32'd0);
    key_rd = 1'b1;
    tick();
    key_rd = 1'b0;
    check("fifo_pop_empty", {31'd0, key_valid}, 32'd0);
    check("fifo_ovf_sticky", {31'd0, overflow}, 32'd1);
`else
    check("pulse_ovf_zero", {31'd0, overflow}, 32'd0);
    check("pulse_code_hold", {28'd0, key_code}, 32'hC);
`endif

    check("col_onehot", oh_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clocks a column is driven before its rows are sampled (legal range >=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 20: consecutive stable samples required for press and for release (legal range >=2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 row_d  input  4  row sense, active-high, already synchronized to clk.
REQ-006 col_q  output  4  column drive, one-hot, active-high.
REQ-007 key_valid  output  1  a key event is available on key_code.
REQ-008 key_code  output  4  hex value of the key event.
REQ-009 key_rd  input  1  consumer acknowledge; pops one event when key_valid=1.
REQ-010 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 SCAN: drive column c, count SETTLE_CYCLES clocks, then sample row_d.
- row_d==0: advance to column c+1, wrapping 3->0.
- Exactly one bit set: go to DEBOUNCE.
- More than one bit set: advance as for row_d==0 (multi-key ignored).
REQ-013 DEBOUNCE: column held; compare row_d to the captured pattern every clock.
- Mismatch: return to SCAN on the same column with the settle count restarted.
- DEBOUNCE_CYCLES consecutive matches (capture sample counts as the first): push the event and go to HELD.
REQ-014 HELD: column held; any nonzero row_d keeps HELD; row_d==0 goes to RELEASE. No auto-repeat.
REQ-015 RELEASE: DEBOUNCE_CYCLES consecutive row_d==0 clocks advance to SCAN on column c+1. Any nonzero row_d returns to HELD with no new event.
REQ-016 key_code map (row r, col c), rows 0..3 top to bottom: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-017 col_q SHALL change only on SCAN column advance and SHALL never be zero or multi-hot.
REQ-018 Press-to-event latency from the capture sample SHALL be exactly DEBOUNCE_CYCLES clocks to key_valid rising.

Reset
REQ-019 nrst low asynchronously forces the following, including mid-debounce or mid-hold:
- state SCAN, col_q=4'b0001, all counters 0;
- key_valid=0, key_code=0, overflow=0;
- event storage emptied.
REQ-020 The first sample after reset release SHALL occur SETTLE_CYCLES clocks later on column 0.

Configuration
REQ-021 Macro KEYPAD_FIFO_EN defined: events are held in a 4-entry FIFO.
- key_valid = not empty; key_code = head entry.
- key_rd with key_valid pops one entry; key_rd while empty is ignored.
- Push while full drops the new event and sets overflow.
- Push and pop in the same clock while full both take effect; nothing is dropped.
REQ-022 Macro KEYPAD_FIFO_EN undefined: no FIFO.
- key_valid is a one-clock pulse per event.
- key_code holds the last event until the next event.
- key_rd is ignored; overflow is tied to 0.

Verification
REQ-023 Reset, row_d=0 -> col_q cycles 0001,0010,0100,1000,0001, 4 clocks per column; key_valid stays 0.
REQ-024 row_d=4'b0010 held while col_q=4'b0100 -> key_valid high 20 clocks after the capture sample, key_code=4'h6, exactly one event while the key is held.
REQ-025 row_d bounces (toggles every 5 clocks for 40 clocks), then stable -> exactly one event after 20 stable clocks; no event during bouncing.
REQ-026 row_d=4'b0011 on any column -> no event; scan continues advancing.
REQ-027 With KEYPAD_FIFO_EN: 5 presses with key_rd=0 -> 4 entries retained in order, overflow=1. Then four key_rd pulses -> codes emerge in press order, then key_valid=0.
REQ-028 nrst asserted during HELD -> outputs at reset values immediately. After release, re-pressing the same key yields a fresh event.
